// File: rtl/conv_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_sequencer
//  Description : Loads an input map and a filter from a byte stream, then
//                drives one shared MAC PE through every convolution window.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_window_sequencer #(
  parameter int IN_DIM = 4,
  parameter int K_DIM  = 3,
  parameter int PE_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] pe_in,
  output logic [7:0] pe_filter,
  output logic [1:0] pe_mode,
  input  logic [7:0] pe_out,
  output logic       busy,
  output logic       res_valid,
  output logic [$clog2((IN_DIM-K_DIM+1)*(IN_DIM-K_DIM+1))-1:0] res_idx,
  output logic [7:0] res_data,
  output logic       done
);

  localparam int OUT_DIM = IN_DIM - K_DIM + 1;
  localparam int N_IN    = IN_DIM * IN_DIM;
  localparam int N_K     = K_DIM * K_DIM;
  localparam int N_OUT   = OUT_DIM * OUT_DIM;
  localparam int BEAT_W  = $clog2(N_IN + N_K + 1);
  localparam int IA_W    = $clog2(N_IN);
  localparam int FA_W    = $clog2(N_K);
  localparam int RI_W    = $clog2(N_OUT);
  localparam int D_W     = $clog2(IN_DIM) + 1;
  localparam int W_W     = $clog2(PE_LAT) + 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(N_IN + N_K - 1);
  localparam logic [BEAT_W-1:0] BEAT_NIN  = BEAT_W'(N_IN);
  localparam logic [D_W-1:0]    K_LAST    = D_W'(K_DIM - 1);
  localparam logic [D_W-1:0]    O_LAST    = D_W'(OUT_DIM - 1);
  localparam logic [W_W-1:0]    LAT_LAST  = W_W'(PE_LAT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  localparam logic [1:0] MODE_HOLD  = 2'd0;
  localparam logic [1:0] MODE_ACC   = 2'd1;
  localparam logic [1:0] MODE_FIRST = 2'd2;

  logic [7:0] in_buf  [N_IN];
  logic [7:0] flt_buf [N_K];

  logic [1:0]        state, nxt_state;
  logic [D_W-1:0]    row, col, ti, tj;
  logic [D_W-1:0]    nxt_row, nxt_col, nxt_ti, nxt_tj;
  logic [W_W-1:0]    wcnt, nxt_wcnt;
  logic [BEAT_W-1:0] beat, nxt_beat;
  logic              accept, capture, last_win;
  logic [IA_W-1:0]   in_rd_addr;
  logic [FA_W-1:0]   flt_rd_addr, flt_wr_addr;
  logic [7:0]        flt_rd_val;

  always_comb begin
    nxt_state = state;
    nxt_row   = row;
    nxt_col   = col;
    nxt_ti    = ti;
    nxt_tj    = tj;
    nxt_wcnt  = wcnt;
    nxt_beat  = beat;
    accept    = 1'b0;
    capture   = 1'b0;
    last_win  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_state = S_LOAD;
          nxt_beat  = '0;
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready) begin
          accept   = 1'b1;
          nxt_beat = beat + BEAT_W'(1);
          if (beat == BEAT_LAST) begin
            nxt_state = S_RUN;
            nxt_row   = '0;
            nxt_col   = '0;
            nxt_ti    = '0;
            nxt_tj    = '0;
          end
        end
      end
      S_RUN: begin
        if (ti == K_LAST && tj == K_LAST) begin
          nxt_state = S_WAIT;
          nxt_wcnt  = '0;
        end else if (tj == K_LAST) begin
          nxt_tj = '0;
          nxt_ti = ti + D_W'(1);
        end else begin
          nxt_tj = tj + D_W'(1);
        end
      end
      default: begin
        if (wcnt == LAT_LAST) begin
          capture = 1'b1;
          nxt_ti  = '0;
          nxt_tj  = '0;
          if (row == O_LAST && col == O_LAST) begin
            last_win  = 1'b1;
            nxt_state = S_IDLE;
          end else begin
            nxt_state = S_RUN;
            if (col == O_LAST) begin
              nxt_col = '0;
              nxt_row = row + D_W'(1);
            end else begin
              nxt_col = col + D_W'(1);
            end
          end
        end else begin
          nxt_wcnt = wcnt + W_W'(1);
        end
      end
    endcase
  end

  // Operands are registered from the next-cycle term so they line up with RUN.
  always_comb begin
    in_rd_addr  = IA_W'((int'(nxt_row) + int'(nxt_ti)) * IN_DIM + int'(nxt_col) + int'(nxt_tj));
    flt_rd_addr = FA_W'((K_DIM - 1 - int'(nxt_ti)) * K_DIM + (K_DIM - 1 - int'(nxt_tj)));
    flt_wr_addr = FA_W'(beat - BEAT_NIN);
    // Term 0 of window 0 needs the last filter byte, written on this very edge.
    if (accept && beat >= BEAT_NIN && flt_wr_addr == flt_rd_addr)
      flt_rd_val = in_data;
    else
      flt_rd_val = flt_buf[flt_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (beat < BEAT_NIN)
        in_buf[IA_W'(beat)] <= in_data;
      else
        flt_buf[flt_wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      ti        <= '0;
      tj        <= '0;
      wcnt      <= '0;
      beat      <= '0;
      in_ready  <= 1'b0;
      pe_in     <= '0;
      pe_filter <= '0;
      pe_mode   <= MODE_HOLD;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_data  <= '0;
      done      <= 1'b0;
    end else begin
      state     <= nxt_state;
      row       <= nxt_row;
      col       <= nxt_col;
      ti        <= nxt_ti;
      tj        <= nxt_tj;
      wcnt      <= nxt_wcnt;
      beat      <= nxt_beat;
      in_ready  <= (nxt_state == S_LOAD);
      busy      <= (nxt_state != S_IDLE) || last_win;
      res_valid <= capture;
      done      <= last_win;
      if (capture) begin
        res_data <= pe_out;
        res_idx  <= RI_W'(int'(row) * OUT_DIM + int'(col));
      end
      if (nxt_state == S_RUN) begin
        pe_in     <= in_buf[in_rd_addr];
        pe_filter <= flt_rd_val;
        pe_mode   <= (nxt_ti == '0 && nxt_tj == '0) ? MODE_FIRST : MODE_ACC;
      end else begin
        pe_in     <= '0;
        pe_filter <= '0;
        pe_mode   <= MODE_HOLD;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_window_sequencer
//  Description : Directed bench; one PE_LAT=1 and one PE_LAT=3 sequencer
//                share the load stream, each with its own 8-bit MAC model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, in_valid;
  logic [7:0] in_data;

  logic       in_ready_a, busy_a, res_valid_a, done_a;
  logic [7:0] pe_in_a, pe_filter_a, pe_out_a, res_data_a;
  logic [1:0] pe_mode_a, res_idx_a;
  logic       in_ready_b, busy_b, res_valid_b, done_b;
  logic [7:0] pe_in_b, pe_filter_b, pe_out_b, res_data_b;
  logic [1:0] pe_mode_b, res_idx_b;

  conv_window_sequencer #(.IN_DIM(4), .K_DIM(3), .PE_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .pe_in(pe_in_a), .pe_filter(pe_filter_a), .pe_mode(pe_mode_a),
    .pe_out(pe_out_a), .busy(busy_a), .res_valid(res_valid_a), .res_idx(res_idx_a),
    .res_data(res_data_a), .done(done_a));

  conv_window_sequencer #(.IN_DIM(4), .K_DIM(3), .PE_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .pe_in(pe_in_b), .pe_filter(pe_filter_b), .pe_mode(pe_mode_b),
    .pe_out(pe_out_b), .busy(busy_b), .res_valid(res_valid_b), .res_idx(res_idx_b),
    .res_data(res_data_b), .done(done_b));

  // PE models: 8-bit accumulator, B delays its output by two extra stages
  logic [7:0] acc_a, acc_b, dly_b1, dly_b2;
  always @(posedge clk or negedge rst) begin
    if (!rst) acc_a <= 8'd0;
    else if (pe_mode_a == 2'd2) acc_a <= pe_in_a * pe_filter_a;
    else if (pe_mode_a == 2'd1) acc_a <= acc_a + pe_in_a * pe_filter_a;
  end
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_b <= 8'd0; dly_b1 <= 8'd0; dly_b2 <= 8'd0;
    end else begin
      if (pe_mode_b == 2'd2) acc_b <= pe_in_b * pe_filter_b;
      else if (pe_mode_b == 2'd1) acc_b <= acc_b + pe_in_b * pe_filter_b;
      dly_b1 <= acc_b;
      dly_b2 <= dly_b1;
    end
  end
  assign pe_out_a = acc_a;
  assign pe_out_b = dly_b2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ra_dat[$], ra_idx[$], ra_cyc[$], m2a[$], da[$];
  int rb_dat[$], rb_idx[$], rb_cyc[$], m2b[$], db[$];
  int beats = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (res_valid_a) begin ra_dat.push_back(int'(res_data_a)); ra_idx.push_back(int'(res_idx_a)); ra_cyc.push_back(cyc); end
      if (res_valid_b) begin rb_dat.push_back(int'(res_data_b)); rb_idx.push_back(int'(res_idx_b)); rb_cyc.push_back(cyc); end
      if (pe_mode_a == 2'd2) m2a.push_back(cyc);
      if (pe_mode_b == 2'd2) m2b.push_back(cyc);
      if (done_a) da.push_back(cyc);
      if (done_b) db.push_back(cyc);
      if (in_valid && in_ready_a) beats++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [7:0] ld [25];
  int exp_res [4];
  int bra, brb, bma, bmb, bda, bdb, bbeats;

  task automatic snap();
    bra = ra_dat.size(); brb = rb_dat.size();
    bma = m2a.size();    bmb = m2b.size();
    bda = da.size();     bdb = db.size();
    bbeats = beats;
  endtask

  task automatic load(input bit gappy);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n < 25; n++) begin
      if (gappy && (n % 2 == 1)) begin
        in_valid = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      in_valid = 1'b1; in_data = ld[n];
      @(posedge clk); #1;
    end
    if (gappy) begin
      in_data = 8'hEE;
      for (int k = 0; k < 4; k++) begin
        start = (k % 2 == 0);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while ((da.size() == bda || db.size() == bdb) && t < 300) begin
      @(negedge clk); t++;
    end
    check({nm, "_done_timeout"}, int'(t < 300), 1);
    repeat (30) @(negedge clk);
  endtask

  task automatic chk_dut(input string nm, input int d[$], input int ix[$], input int cy[$],
                         input int m2[$], input int dn[$], input int br, input int bm,
                         input int bd, input int per);
    check({nm, "_res_cnt"}, d.size() - br, 4);
    for (int k = 0; k < 4; k++) begin
      if (br + k < d.size()) begin
        check($sformatf("%s_idx%0d", nm, k), ix[br+k], k);
        check($sformatf("%s_data%0d", nm, k), d[br+k], exp_res[k]);
        if (k > 0) check($sformatf("%s_gap%0d", nm, k), cy[br+k] - cy[br+k-1], per);
      end
    end
    check({nm, "_done_cnt"}, dn.size() - bd, 1);
    if (dn.size() > bd && d.size() >= br + 4)
      check({nm, "_done_with_last"}, dn[bd] - cy[br+3], 0);
    if (dn.size() > bd && m2.size() > bm)
      check({nm, "_run_to_done"}, dn[bd] - m2[bm], 4 * per);
  endtask

  task automatic job(input string nm, input bit gappy, input int e0, input int e1,
                     input int e2, input int e3);
    exp_res[0] = e0; exp_res[1] = e1; exp_res[2] = e2; exp_res[3] = e3;
    snap();
    load(gappy);
    wait_done(nm);
    check({nm, "_beats"}, beats - bbeats, 25);
    chk_dut({nm, "_a"}, ra_dat, ra_idx, ra_cyc, m2a, da, bra, bma, bda, 10);
    chk_dut({nm, "_b"}, rb_dat, rb_idx, rb_cyc, m2b, db, brb, bmb, bdb, 12);
    check({nm, "_idle"}, int'({busy_a, busy_b, in_ready_a, in_ready_b}), 0);
  endtask

  function automatic int outs_a();
    return int'({in_ready_a, pe_in_a, pe_filter_a, pe_mode_a, busy_a, res_valid_a,
                 res_idx_a, res_data_a, done_a});
  endfunction
  function automatic int outs_b();
    return int'({in_ready_b, pe_in_b, pe_filter_b, pe_mode_b, busy_b, res_valid_b,
                 res_idx_b, res_data_b, done_b});
  endfunction

  initial begin
    int t;
    int sa, sb, sda, sdb;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (2) @(negedge clk);
    check("reset_outs_a", outs_a(), 0);
    check("reset_outs_b", outs_b(), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 25; n++) ld[n] = 8'd1;
    job("ones", 1'b0, 9, 9, 9, 9);

    for (int n = 0; n < 16; n++) ld[n] = 8'(n + 1);
    for (int n = 16; n < 25; n++) ld[n] = 8'd0;
    ld[20] = 8'd1;
    job("centre", 1'b0, 6, 7, 10, 11);

    ld[20] = 8'd0; ld[24] = 8'd1;
    job("flip", 1'b0, 1, 2, 5, 6);

    for (int n = 0; n < 16; n++) ld[n] = 8'd255;
    for (int n = 16; n < 25; n++) ld[n] = 8'd1;
    job("wrap", 1'b0, 247, 247, 247, 247);

    for (int n = 0; n < 16; n++) ld[n] = 8'(n + 1);
    for (int n = 16; n < 25; n++) ld[n] = 8'd0;
    ld[20] = 8'd1;
    job("gappy", 1'b1, 6, 7, 10, 11);

    // abort during window 2, then a clean job
    for (int n = 0; n < 25; n++) ld[n] = 8'd1;
    snap();
    load(1'b0);
    t = 0;
    while (ra_dat.size() < bra + 2 && t < 200) begin
      @(negedge clk); t++;
    end
    check("abort_reach_win2", int'(t < 200), 1);
    rst = 1'b0;
    #1;
    check("abort_outs_a", outs_a(), 0);
    check("abort_outs_b", outs_b(), 0);
    sa = ra_dat.size(); sb = rb_dat.size(); sda = da.size(); sdb = db.size();
    @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_no_res_a", ra_dat.size() - sa, 0);
    check("abort_no_res_b", rb_dat.size() - sb, 0);
    check("abort_no_done_a", da.size() - sda, 0);
    check("abort_no_done_b", db.size() - sdb, 0);
    check("abort_busy", int'({busy_a, busy_b}), 0);

    job("fresh", 1'b0, 9, 9, 9, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Controller that loads one input feature map and one filter over a byte stream, then sequences a single shared MAC processing element (PE) through every convolution window.
- Captures one PE result per output window and emits it on a result strobe.
- Sits between the data loader and the single-PE array datapath, replacing hard-coded per-term state enumeration with counters.
- Default configuration is a 4x4 input and a 3x3 filter, giving a 2x2 output.

Parameters:
- IN_DIM, 4, input feature map is IN_DIM x IN_DIM bytes.
- K_DIM, 3, filter is K_DIM x K_DIM bytes; OUT_DIM = IN_DIM-K_DIM+1.
- PE_LAT, 1, cycles from a term being driven on the PE ports to the updated accumulator appearing on pe_out (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a load+compute job.
- in_valid  input  1  load stream beat valid.
- in_data  input  8  load stream byte: IN_DIM*IN_DIM input bytes (raster order), then K_DIM*K_DIM filter bytes (raster order).
- in_ready  output  1  high only in LOAD.
- pe_in  output  8  input operand to PE.
- pe_filter  output  8  filter operand to PE.
- pe_mode  output  2  0=hold, 1=accumulate (acc+=in*filter), 2=load first product (acc=in*filter).
- pe_out  input  8  PE accumulator.
- busy  output  1  high whenever state != IDLE.
- res_valid  output  1  one-cycle strobe, result on res_data/res_idx.
- res_idx  output  $clog2(OUT_DIM*OUT_DIM)  raster index of the window (r*OUT_DIM+c).
- res_data  output  8  captured pe_out.
- done  output  1  one-cycle pulse, coincident with the final res_valid.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; counters 0. Buffer contents need not be cleared. Reset mid-job aborts the job: no res_valid and no done follow.
- All outputs are registered.
- States: IDLE, LOAD, RUN, WAIT.
- IDLE: start=1 -> LOAD at next edge. start is ignored in every other state.
- LOAD: in_ready=1. A beat is accepted when in_valid&in_ready. Beat n < IN_DIM^2 writes input[n]; later beats write filter[n-IN_DIM^2]. Gaps in in_valid are allowed. The edge accepting the final filter beat -> RUN with window (0,0) and term 0.
- RUN: one term per cycle. Term t=(i,j), i,j in 0..K_DIM-1, row-major.
  - pe_in = input[r+i][c+j]; pe_filter = filter[K_DIM-1-i][K_DIM-1-j] (true convolution, flipped kernel).
  - pe_mode = 2 for t=0, 1 otherwise.
  - After the term K_DIM^2-1 cycle -> WAIT.
- WAIT: lasts PE_LAT cycles; pe_mode=0, pe_in=pe_filter=0.
  - The edge ending the last WAIT cycle captures pe_out into res_data, sets res_idx, and asserts res_valid for one cycle.
  - At that same edge: if the window was not the last, go to RUN on the next window (c increments, wrapping to c=0 with r+1), and term 0 of the next window issues in the same cycle as res_valid. If it was the last window, go to IDLE and assert done with res_valid.
- Outside RUN: pe_in=pe_filter=0, pe_mode=0.
- Per-window period is K_DIM^2+PE_LAT cycles. With defaults, done is asserted 40 cycles after the RUN entry edge.
- Arithmetic is fully inside the PE; pe_out is taken as-is, 8-bit, with no widening or saturation here.
- busy stays high from the LOAD entry edge through the cycle carrying done, and drops the cycle after.
- Results are never back-pressured.

Test Plan:
- All 25 load bytes = 1 with PE model acc 8-bit -> res_valid x4 with res_idx 0,1,2,3, all res_data=9; done with idx 3; no other res_valid.
- Input bytes 1..16 raster, filter only centre (raster 4) = 1 -> results 6,7,10,11. Filter only raster 8 = 1 (flip check) -> results 1,2,5,6.
- Input all 255, filter all 1 -> every result 247 (2295 mod 256). Check that term-0 pe_mode=2 clears the prior window's sum, so window 1 is not 238.
- in_valid toggling 1/0 during LOAD with pulses of start mid-job -> exactly 25 beats are accepted, no second job starts, and results match the contiguous-load run.
- Drive rst=0 for one cycle during window 2 RUN -> all outputs 0 immediately. No done is produced. A fresh start afterwards completes normally with correct results.
- PE_LAT=3 build -> period is 12 cycles per window; res_valid spacing is 12; results are identical to the default run.
